// File: rtl/pe_array.sv
// Four-PE array: each PE steps FETCH/READ/EXEC over its own 16-word program
// and 16-word local memory; the host loads memories through a shared port.
module pe_array (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  start_in,
    input  logic [5:0]  CFG_addra_in,
    input  logic [31:0] CFG_dina_in,
    input  logic        CFG_ena_in,
    input  logic        CFG_wea_in,
    input  logic [7:0]  CFG_incr_in,
    input  logic [5:0]  LDM_addra_in,
    input  logic [31:0] LDM_dina_in,
    input  logic        LDM_ena_in,
    input  logic        LDM_wea_in,
    output logic [31:0] LDM_douta_out,
    output logic        LDM_douta_valid_out
);
    localparam int PE_NUM = 4;

    typedef enum logic [1:0] {IDLE, FETCH, READ, EXEC} pe_state_t;

    logic [31:0]       cfg_mem  [PE_NUM][16];
    logic [31:0]       ldm_mem  [PE_NUM][16];
    logic [PE_NUM-1:0] start_q;
    logic [PE_NUM-1:0] busy;
    logic [PE_NUM-1:0] pe_we;
    logic [3:0]        pe_waddr [PE_NUM];
    logic [31:0]       pe_wdata [PE_NUM];
    logic [3:0]        len_m1;
    logic              cfg_host_we;
    logic              ldm_host_we;
    logic              ldm_host_re;
    logic [6:0]        unused_bits;

    assign unused_bits = {start_in[7:4], CFG_incr_in[7:5]};

    // Zero or out-of-range lengths run the full 16-instruction program.
    always_comb begin
        len_m1 = 4'hF;
        if (CFG_incr_in[4:0] != 5'd0 && CFG_incr_in[4:0] <= 5'd16)
            len_m1 = CFG_incr_in[3:0] - 4'd1;
    end

    function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [15:0] imm);
        logic [63:0] rot;
        rot = {32'b0, a} << b[4:0];
        alu = '0;
        case (op)
            4'd1:    alu = a + b;
            4'd2:    alu = a - b;
            4'd3:    alu = a & b;
            4'd4:    alu = a | b;
            4'd5:    alu = a ^ b;
            4'd6:    alu = a << b[4:0];
            4'd7:    alu = a >> b[4:0];
            4'd8:    alu = a * b;
            4'd9:    alu = a + {{16{imm[15]}}, imm};
            4'd10:   alu = {16'b0, imm};
            4'd11:   alu = a;
            4'd12:   alu = rot[31:0] | rot[63:32];
            default: alu = '0;
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) start_q <= '0;
        else     start_q <= start_in[PE_NUM-1:0];
    end

    for (genvar k = 0; k < PE_NUM; k++) begin : g_pe
        pe_state_t   state_q, state_d;
        logic [3:0]  pc_q, last_q;
        logic [31:0] instr_q, a_q, b_q;
        logic        launch;

        assign launch  = start_in[k] & ~start_q[k] & (state_q == IDLE);
        assign busy[k] = (state_q != IDLE);

        always_comb begin
            state_d = state_q;
            case (state_q)
                IDLE:    if (launch) state_d = FETCH;
                FETCH:   state_d = READ;
                READ:    state_d = EXEC;
                EXEC:    state_d = (pc_q == last_q) ? IDLE : FETCH;
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                state_q <= IDLE;
                pc_q    <= '0;
                last_q  <= '0;
            end else begin
                state_q <= state_d;
                if (launch) begin
                    pc_q   <= '0;
                    last_q <= len_m1;
                end
                if (state_q == EXEC) pc_q <= (pc_q == last_q) ? 4'd0 : pc_q + 4'd1;
            end
            if (state_q == FETCH) instr_q <= cfg_mem[k][pc_q];
            if (state_q == READ) begin
                a_q <= ldm_mem[k][instr_q[23:20]];
                b_q <= ldm_mem[k][instr_q[19:16]];
            end
        end

        assign pe_we[k]    = (state_q == EXEC) && (instr_q[31:28] >= 4'd1) && (instr_q[31:28] <= 4'd12);
        assign pe_waddr[k] = instr_q[27:24];
        assign pe_wdata[k] = alu(instr_q[31:28], a_q, b_q, instr_q[15:0]);
    end

    // Host writes to a running PE are dropped, so they never collide with PE writes.
    assign cfg_host_we = CFG_ena_in & CFG_wea_in & ~busy[CFG_addra_in[5:4]];
    assign ldm_host_we = LDM_ena_in & LDM_wea_in & ~busy[LDM_addra_in[5:4]];
    assign ldm_host_re = LDM_ena_in & ~LDM_wea_in;

    always_ff @(posedge CLK) begin
        for (int k = 0; k < PE_NUM; k++) begin
            if (pe_we[k]) ldm_mem[k][pe_waddr[k]] <= pe_wdata[k];
        end
        if (ldm_host_we) ldm_mem[LDM_addra_in[5:4]][LDM_addra_in[3:0]] <= LDM_dina_in;
        if (cfg_host_we) cfg_mem[CFG_addra_in[5:4]][CFG_addra_in[3:0]] <= CFG_dina_in;
    end

    // Read data is qualified by a one-cycle valid pulse; data holds when valid is low.
    always_ff @(posedge CLK) begin
        if (RST) begin
            LDM_douta_out       <= '0;
            LDM_douta_valid_out <= 1'b0;
        end else begin
            LDM_douta_valid_out <= ldm_host_re;
            if (ldm_host_re) LDM_douta_out <= ldm_mem[LDM_addra_in[5:4]][LDM_addra_in[3:0]];
        end
    end
endmodule

// File: tb/tb_pe_array.sv
// Directed bench for pe_array: host memory access, program runs, busy
// protection and mid-run reset, checked with immediate assertions.
module tb_pe_array;
    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  start_in;
    logic [5:0]  CFG_addra_in;
    logic [31:0] CFG_dina_in;
    logic        CFG_ena_in;
    logic        CFG_wea_in;
    logic [7:0]  CFG_incr_in;
    logic [5:0]  LDM_addra_in;
    logic [31:0] LDM_dina_in;
    logic        LDM_ena_in;
    logic        LDM_wea_in;
    logic [31:0] LDM_douta_out;
    logic        LDM_douta_valid_out;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    pe_array dut (
        .CLK(CLK), .RST(RST), .start_in(start_in),
        .CFG_addra_in(CFG_addra_in), .CFG_dina_in(CFG_dina_in), .CFG_ena_in(CFG_ena_in),
        .CFG_wea_in(CFG_wea_in), .CFG_incr_in(CFG_incr_in),
        .LDM_addra_in(LDM_addra_in), .LDM_dina_in(LDM_dina_in), .LDM_ena_in(LDM_ena_in),
        .LDM_wea_in(LDM_wea_in), .LDM_douta_out(LDM_douta_out),
        .LDM_douta_valid_out(LDM_douta_valid_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic cfg_write(input int pe, input int word, input logic [31:0] data, input logic we);
        CFG_addra_in = {pe[1:0], word[3:0]};
        CFG_dina_in  = data;
        CFG_ena_in   = 1'b1;
        CFG_wea_in   = we;
        @(negedge CLK);
        CFG_ena_in   = 1'b0;
        CFG_wea_in   = 1'b0;
    endtask

    task automatic ldm_write(input int pe, input int word, input logic [31:0] data);
        LDM_addra_in = {pe[1:0], word[3:0]};
        LDM_dina_in  = data;
        LDM_ena_in   = 1'b1;
        LDM_wea_in   = 1'b1;
        @(negedge CLK);
        LDM_ena_in   = 1'b0;
        LDM_wea_in   = 1'b0;
    endtask

    task automatic ldm_read_check(input int pe, input int word, input logic [31:0] exp, input string tag);
        LDM_addra_in = {pe[1:0], word[3:0]};
        LDM_ena_in   = 1'b1;
        LDM_wea_in   = 1'b0;
        @(negedge CLK);
        LDM_ena_in   = 1'b0;
        check({tag, "_valid"}, {31'b0, LDM_douta_valid_out}, 32'd1);
        check(tag, LDM_douta_out, exp);
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1; start_in = '0; CFG_addra_in = '0; CFG_dina_in = '0; CFG_ena_in = 1'b0;
        CFG_wea_in = 1'b0; CFG_incr_in = '0; LDM_addra_in = '0; LDM_dina_in = '0;
        LDM_ena_in = 1'b0; LDM_wea_in = 1'b0;
        tick(3);
        RST = 1'b0;
        check("reset_douta", LDM_douta_out, 32'h0);
        check("reset_valid", {31'b0, LDM_douta_valid_out}, 32'h0);
        check("reset_busy", {28'b0, dut.busy}, 32'h0);

        // Host write then read, valid is a single-cycle pulse
        ldm_write(2, 5, 32'hDEADBEEF);
        LDM_addra_in = {2'd2, 4'd5}; LDM_ena_in = 1'b1; LDM_wea_in = 1'b0;
        tick(1);
        LDM_ena_in = 1'b0;
        check("host_rd_valid", {31'b0, LDM_douta_valid_out}, 32'd1);
        check("host_rd_data", LDM_douta_out, 32'hDEADBEEF);
        tick(1);
        check("host_rd_valid_drop", {31'b0, LDM_douta_valid_out}, 32'd0);
        check("host_rd_data_hold", LDM_douta_out, 32'hDEADBEEF);

        // Single ADD on PE0; a CFG access with wea=0 must not overwrite it
        cfg_write(0, 0, 32'h1201_0000, 1'b1);
        cfg_write(0, 0, 32'hA200_0000, 1'b0);
        ldm_write(0, 0, 32'd3);
        ldm_write(0, 1, 32'd4);
        ldm_write(0, 2, 32'd0);
        CFG_incr_in = 8'd1; start_in = 8'b0000_0001;
        tick(1);
        start_in = '0;
        check("add_busy_start", {28'b0, dut.busy}, 32'h1);
        tick(2);
        check("add_busy_mid", {28'b0, dut.busy}, 32'h1);
        tick(1);
        check("add_idle_end", {28'b0, dut.busy}, 32'h0);
        ldm_read_check(0, 2, 32'd7, "add_result");

        // PE1 chained LDI/ADDI and PE2 ALU sweep, overlapping in time
        cfg_write(1, 0, 32'hA000_FFFF, 1'b1);
        cfg_write(1, 1, 32'h9100_0001, 1'b1);
        cfg_write(2, 0, 32'h1201_0000, 1'b1);
        cfg_write(2, 1, 32'h6301_0000, 1'b1);
        cfg_write(2, 2, 32'hC401_0000, 1'b1);
        cfg_write(2, 3, 32'h7501_0000, 1'b1);
        cfg_write(2, 4, 32'h8601_0000, 1'b1);
        cfg_write(2, 5, 32'h2710_0000, 1'b1);
        cfg_write(2, 6, 32'h5801_0000, 1'b1);
        cfg_write(2, 7, 32'hB900_0000, 1'b1);
        cfg_write(2, 8, 32'h9A00_FFFE, 1'b1);
        cfg_write(2, 9, 32'hDB00_0000, 1'b1);
        cfg_write(2, 10, 32'hCDC1_0000, 1'b1);
        ldm_write(2, 0, 32'hFFFF_FFFF);
        ldm_write(2, 1, 32'h0000_0001);
        ldm_write(2, 11, 32'h1234_5678);
        ldm_write(2, 12, 32'h8000_0001);
        CFG_incr_in = 8'd11; start_in = 8'b0000_0100;
        tick(1);
        CFG_incr_in = 8'd2; start_in = 8'b0000_0110;
        tick(1);
        start_in = '0;
        tick(5);
        check("chain_busy_mid", {28'b0, dut.busy}, 32'h6);
        tick(1);
        check("chain_pe1_done", {28'b0, dut.busy}, 32'h4);
        tick(25);
        check("alu_busy_mid", {28'b0, dut.busy}, 32'h4);
        tick(1);
        check("alu_idle_end", {28'b0, dut.busy}, 32'h0);
        ldm_read_check(1, 0, 32'h0000_FFFF, "chain_ldi");
        ldm_read_check(1, 1, 32'h0001_0000, "chain_addi");
        ldm_read_check(2, 2, 32'h0000_0000, "alu_add_wrap");
        ldm_read_check(2, 3, 32'hFFFF_FFFE, "alu_shl");
        ldm_read_check(2, 4, 32'hFFFF_FFFF, "alu_rotl_ones");
        ldm_read_check(2, 5, 32'h7FFF_FFFF, "alu_shr");
        ldm_read_check(2, 6, 32'hFFFF_FFFF, "alu_mul");
        ldm_read_check(2, 7, 32'h0000_0002, "alu_sub_wrap");
        ldm_read_check(2, 8, 32'hFFFF_FFFE, "alu_xor");
        ldm_read_check(2, 9, 32'hFFFF_FFFF, "alu_mov");
        ldm_read_check(2, 10, 32'hFFFF_FFFD, "alu_addi_neg");
        ldm_read_check(2, 11, 32'h1234_5678, "alu_nop13");
        ldm_read_check(2, 13, 32'h0000_0003, "alu_rotl_carry");

        // Simultaneous launch of PE0 and PE1
        ldm_write(0, 2, 32'd0);
        ldm_write(1, 0, 32'd0);
        CFG_incr_in = 8'd1; start_in = 8'b0000_0011;
        tick(1);
        start_in = '0;
        tick(2);
        check("multi_busy", {28'b0, dut.busy}, 32'h3);
        tick(1);
        check("multi_idle", {28'b0, dut.busy}, 32'h0);
        ldm_read_check(0, 2, 32'd7, "multi_pe0");
        ldm_read_check(1, 0, 32'h0000_FFFF, "multi_pe1");

        // PE3 full 16-instruction run with host writes attempted mid-run
        for (int i = 0; i < 16; i++) cfg_write(3, i, 32'h9110_0001, 1'b1);
        ldm_write(3, 0, 32'hAAAA_0000);
        ldm_write(3, 1, 32'd100);
        CFG_incr_in = 8'd0; start_in = 8'b0000_1000;
        tick(1);
        tick(10);
        ldm_write(3, 0, 32'h5555_5555);
        cfg_write(3, 15, 32'hA100_0000, 1'b1);
        ldm_read_check(3, 0, 32'hAAAA_0000, "busy_host_read");
        tick(33);
        check("busy_n16_mid", {28'b0, dut.busy}, 32'h8);
        tick(1);
        check("busy_n16_end", {28'b0, dut.busy}, 32'h0);
        tick(10);
        check("busy_no_relaunch", {28'b0, dut.busy}, 32'h0);
        start_in = '0;
        ldm_read_check(3, 0, 32'hAAAA_0000, "busy_ldm_drop");
        ldm_read_check(3, 1, 32'd116, "busy_cfg_drop");

        // Reset during cycle 4 of an N=4 run on PE0
        cfg_write(0, 0, 32'hA300_1111, 1'b1);
        cfg_write(0, 1, 32'hA400_2222, 1'b1);
        cfg_write(0, 2, 32'hA500_3333, 1'b1);
        cfg_write(0, 3, 32'hA600_4444, 1'b1);
        for (int i = 3; i < 7; i++) ldm_write(0, i, 32'd0);
        ldm_read_check(0, 2, 32'd7, "pre_reset_read");
        CFG_incr_in = 8'd4; start_in = 8'b0000_0001;
        tick(1);
        start_in = '0;
        tick(3);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        check("rst_busy", {28'b0, dut.busy}, 32'h0);
        check("rst_douta", LDM_douta_out, 32'h0);
        check("rst_valid", {31'b0, LDM_douta_valid_out}, 32'h0);
        tick(10);
        ldm_read_check(0, 3, 32'h0000_1111, "rst_first_kept");
        ldm_read_check(0, 4, 32'h0000_0000, "rst_second_skipped");
        ldm_read_check(0, 5, 32'h0000_0000, "rst_third_skipped");

        // After reset a new run starts from PC 0
        ldm_write(0, 3, 32'd0);
        CFG_incr_in = 8'd1; start_in = 8'b0000_0001;
        tick(1);
        start_in = '0;
        tick(3);
        check("rst_relaunch_idle", {28'b0, dut.busy}, 32'h0);
        ldm_read_check(0, 3, 32'h0000_1111, "rst_relaunch_pc0");
        ldm_read_check(0, 4, 32'h0000_0000, "rst_relaunch_len");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pe_array.md
PE_ARRAY -- requirements
Module: pe_array

Interface
REQ-001 Parameters (all fixed): PE_NUM_BITS=2 (4 PEs); PE_CFG_ADDR_BITS=4 (16 instructions per PE); PE_CFG_BITS=32; LDM_ADDR_BITS=4 (16 words per PE); AXI_DWIDTH_BITS=32.
REQ-002 Single clock; reset is synchronous and active-high.
REQ-003 Ports: CLK in 1 (clock); RST in 1 (sync reset, active-high).
REQ-004 Ports: start_in in 8; bit k launches PE k; bits 7:4 ignored.
REQ-005 Ports: CFG_addra_in in 6 ([5:4] PE, [3:0] word); CFG_dina_in in 32; CFG_ena_in in 1; CFG_wea_in in 1; CFG_incr_in in 8 (program length).
REQ-006 Ports: LDM_addra_in in 6 ([5:4] PE, [3:0] word); LDM_dina_in in 32; LDM_ena_in in 1; LDM_wea_in in 1.
REQ-007 Ports: LDM_douta_out out 32 (host read data); LDM_douta_valid_out out 1 (read data valid).

Function
REQ-008 Each PE has a 16x32 configuration memory (CFG) and a 16x32 local data memory (LDM), both registered-read, with a host port and a PE-internal port.
REQ-009 Host CFG write: CFG_ena_in=1 and CFG_wea_in=1 writes CFG_dina_in to the addressed PE/word at the clock edge; CFG_ena_in=1 with CFG_wea_in=0 does nothing.
REQ-010 Host LDM write: LDM_ena_in=1 and LDM_wea_in=1 writes LDM_dina_in to the addressed PE/word.
REQ-011 Host LDM read: LDM_ena_in=1 and LDM_wea_in=0 places the addressed word on LDM_douta_out one cycle later; LDM_douta_valid_out=1 for exactly that cycle; otherwise valid=0 and data holds its last value.
REQ-012 Host CFG/LDM writes to a PE whose run is active are dropped; host reads of a busy PE are allowed and return the currently stored word.
REQ-013 Launch is edge-triggered: a 0->1 transition of start_in[k] (versus its registered previous value) while PE k is IDLE starts a run at PC=0; the transition is ignored while PE k is busy.
REQ-014 Program length N = CFG_incr_in[4:0], sampled at launch; 0 or >16 is treated as 16.
REQ-015 Per-PE FSM: IDLE -> FETCH (read CFG[PC]) -> READ (read LDM[srcA], LDM[srcB]) -> EXEC (compute, write LDM[dst]) -> FETCH with PC+1, or -> IDLE after the instruction at PC=N-1; each instruction takes 3 cycles; a run takes 3N cycles.
REQ-016 Instruction fields: [31:28] opcode, [27:24] dst, [23:20] srcA, [19:16] srcB, [15:0] imm.
REQ-017 Opcodes (A=LDM[srcA], B=LDM[srcB]; 32-bit results, overflow wraps): 0 NOP (no write); 1 ADD A+B; 2 SUB A-B; 3 AND; 4 OR; 5 XOR; 6 SHL A<<B[4:0]; 7 SHR logical A>>B[4:0]; 8 MUL low 32 bits of A*B; 9 ADDI A+signext(imm); 10 LDI zeroext(imm); 11 MOV A; 12 ROTL A rotated left by B[4:0]; 13-15 NOP.
REQ-018 Operands are read in READ, so an instruction sees results written by the previous instruction (dst==src forwarding is not needed).
REQ-019 The four PEs run independently and concurrently; simultaneous starts on multiple bits launch all the selected PEs in the same cycle.

Reset
REQ-020 RST=1 at a clock edge forces every PE to IDLE with PC=0, clears the start-edge registers, and sets LDM_douta_out=0 and LDM_douta_valid_out=0.
REQ-021 Reset does not clear CFG or LDM contents; a reset during a run aborts it, keeping all writes already completed.

Verification
REQ-022 Host write then read: write 0xDEADBEEF to LDM PE2 word 5; read the same address -> next cycle douta=0xDEADBEEF, valid=1 for one cycle.
REQ-023 ADD run: PE0 LDM[0]=3, LDM[1]=4; CFG[0]=0x1201_0000 (dst2=A0+B1); CFG_incr_in=1; pulse start_in[0] -> after 3 cycles LDM[2]=7, PE0 IDLE.
REQ-024 Chained program: PE1 CFG = LDI d0,#0xFFFF; ADDI d1=d0+1 (imm 1); CFG_incr_in=2 -> LDM[0]=0x0000FFFF and LDM[1]=0x00010000 after 6 cycles.
REQ-025 Busy protection: start PE3 with N=16 and write LDM PE3 word 0 mid-run -> write dropped; start_in[3] held high through the run -> no relaunch without a new 0->1 edge.
REQ-026 Reset mid-run: assert RST at cycle 4 of an N=4 run -> PE IDLE, outputs 0, first instruction's result retained, later instructions not executed.
REQ-027 Wrap and shift: A=0xFFFFFFFF, B=1: ADD -> 0, SHL -> 0xFFFFFFFE, ROTL -> 0xFFFFFFFF, SHR -> 0x7FFFFFFF.
